// File: rtl/rob_retire_unit.sv
// rob_retire_unit: 2-wide in-order reorder buffer with retirement.
// Entries are allocated at tail by id_stage, marked done by execute, and
// retired from head in program order, up to two per cycle. A retiring
// mispredicted branch flushes the buffer and raises a one-cycle squash.
// A retiring halt freezes the unit until reset.
//
// Handshake: dispatch is fire-and-forget. The producer watches rob_stall,
// which is high when fewer than two entries are free. A dispatch group
// that does not fit is dropped as a whole. Completions carry the tag
// returned on dispatch_tag and need no acknowledgement.
//
// The dbg_* outputs expose the pointer state to checkers.
module rob_retire_unit #(
  parameter int ROB_DEPTH = 32,
  parameter int PRF_W     = 6,
  localparam int ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  dispatch_valid,
  input  logic [1:0][4:0]             dispatch_arn,
  input  logic [1:0][PRF_W-1:0]       dispatch_prn,
  input  logic [1:0]                  dispatch_reg_write,
  input  logic [1:0][31:0]            dispatch_pc,
  input  logic [1:0]                  dispatch_is_branch,
  input  logic [1:0]                  dispatch_halt,
  output logic [1:0][ROB_W-1:0]       dispatch_tag,
  output logic                        rob_stall,
  input  logic [1:0]                  complete_valid,
  input  logic [1:0][ROB_W-1:0]       complete_tag,
  input  logic [1:0]                  complete_taken,
  input  logic [1:0][31:0]            complete_target,
  input  logic [1:0]                  complete_mispredict,
  output logic [1:0]                  rob_retire,
  output logic [1:0][4:0]             ARCH_ARF_idx,
  output logic [1:0][PRF_W-1:0]       ARCH_PRF_idx,
  output logic [1:0]                  retired,
  output logic [1:0][PRF_W-1:0]       dest_PRN_out,
  output logic [1:0]                  valid_update,
  output logic [1:0][31:0]            PC_update,
  output logic [1:0]                  direction_update,
  output logic [1:0][31:0]            target_update,
  output logic                        squash,
  output logic [31:0]                 squash_pc,
  output logic                        halt_retired,
  output logic [ROB_W:0]              dbg_count,
  output logic [ROB_W-1:0]            dbg_head,
  output logic [ROB_W-1:0]            dbg_tail
);

  localparam logic [ROB_W:0] DEPTH_C = (ROB_W+1)'(ROB_DEPTH);

  // Pointer state.
  logic [ROB_W-1:0] head, tail;
  logic [ROB_W:0]   count;

  // Entry storage.
  logic [ROB_DEPTH-1:0] e_done;
  logic [4:0]           e_arn    [ROB_DEPTH];
  logic [PRF_W-1:0]     e_prn    [ROB_DEPTH];
  logic                 e_rw     [ROB_DEPTH];
  logic [31:0]          e_pc     [ROB_DEPTH];
  logic                 e_br     [ROB_DEPTH];
  logic                 e_halt   [ROB_DEPTH];
  logic                 e_taken  [ROB_DEPTH];
  logic [31:0]          e_target [ROB_DEPTH];
  logic                 e_misp   [ROB_DEPTH];

  // Combinational control.
  logic [ROB_W-1:0] head1, tail1;
  logic [ROB_W:0]   free;
  logic [1:0]       disp_n, disp_acc, ret_n;
  logic             disp_ok, wr0, wr1;
  logic [1:0]       ret;
  logic [1:0][ROB_W-1:0] ridx;
  logic             flush, halt_hit;
  logic [31:0]      flush_pc;
  logic [1:0]       hit;
  logic [1:0][ROB_W-1:0] off;

  // Next values of the registered retire-side outputs.
  logic [1:0]             rob_retire_d, valid_update_d, direction_update_d;
  logic [1:0][4:0]        arf_d;
  logic [1:0][PRF_W-1:0]  prf_d;
  logic [1:0][31:0]       pc_d, target_d;

  assign dispatch_tag = {tail1, tail};
  assign rob_stall    = (free < (ROB_W+1)'(2));
  assign dbg_count    = count;
  assign dbg_head     = head;
  assign dbg_tail     = tail;

  // Dispatch acceptance, retire selection, flush and completion-hit decode.
  always_comb begin
    head1    = head + ROB_W'(1);
    tail1    = tail + ROB_W'(1);
    free     = DEPTH_C - count;
    disp_n   = dispatch_valid[0] ? (dispatch_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    disp_ok  = !squash && !halt_retired && (free >= (ROB_W+1)'(disp_n));
    disp_acc = disp_ok ? disp_n : 2'd0;
    wr0      = disp_ok && dispatch_valid[0];
    wr1      = wr0 && dispatch_valid[1];

    ridx[0]  = head;
    ridx[1]  = head1;
    ret[0]   = !halt_retired && (count != '0) && e_done[head];
    ret[1]   = ret[0] && (count >= (ROB_W+1)'(2)) && e_done[head1] &&
               !e_misp[head] && !e_halt[head];
    ret_n    = {1'b0, ret[0]} + {1'b0, ret[1]};

    flush    = (ret[0] && e_misp[head]) || (ret[1] && e_misp[head1]);
    flush_pc = (ret[1] && e_misp[head1]) ? e_target[head1] : e_target[head];
    halt_hit = (ret[0] && e_halt[head]) || (ret[1] && e_halt[head1]);

    // A completion only counts if its tag lies inside [head, head+count).
    for (int i = 0; i < 2; i++) begin
      off[i] = complete_tag[i] - head;
      hit[i] = complete_valid[i] && ({1'b0, off[i]} < count);
    end
  end

  // Per-slot retire payload, zeroed when the slot does not retire.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rob_retire_d[i]       = ret[i] && e_rw[ridx[i]];
      arf_d[i]              = rob_retire_d[i] ? e_arn[ridx[i]] : 5'd0;
      prf_d[i]              = rob_retire_d[i] ? e_prn[ridx[i]] : '0;
      valid_update_d[i]     = ret[i] && e_br[ridx[i]];
      pc_d[i]               = valid_update_d[i] ? e_pc[ridx[i]] : 32'd0;
      direction_update_d[i] = valid_update_d[i] && e_taken[ridx[i]];
      target_d[i]           = valid_update_d[i] ? e_target[ridx[i]] : 32'd0;
    end
  end

  // Head/tail/count update; a flush empties the buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ROB_W'(ret_n);
      tail  <= tail + ROB_W'(disp_acc);
      count <= count + (ROB_W+1)'(disp_acc) - (ROB_W+1)'(ret_n);
    end
  end

  // Done bits: cleared on allocation, set on completion, wiped on flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_done <= '0;
    end else if (flush) begin
      e_done <= '0;
    end else begin
      if (wr0)    e_done[tail]            <= 1'b0;
      if (wr1)    e_done[tail1]           <= 1'b0;
      if (hit[0]) e_done[complete_tag[0]] <= 1'b1;
      if (hit[1]) e_done[complete_tag[1]] <= 1'b1;
    end
  end

  // Entry payload; contents are only meaningful while the done bit tracks them.
  always_ff @(posedge clock) begin
    if (wr0) begin
      e_arn[tail]  <= dispatch_arn[0];
      e_prn[tail]  <= dispatch_prn[0];
      e_rw[tail]   <= dispatch_reg_write[0];
      e_pc[tail]   <= dispatch_pc[0];
      e_br[tail]   <= dispatch_is_branch[0];
      e_halt[tail] <= dispatch_halt[0];
    end
    if (wr1) begin
      e_arn[tail1]  <= dispatch_arn[1];
      e_prn[tail1]  <= dispatch_prn[1];
      e_rw[tail1]   <= dispatch_reg_write[1];
      e_pc[tail1]   <= dispatch_pc[1];
      e_br[tail1]   <= dispatch_is_branch[1];
      e_halt[tail1] <= dispatch_halt[1];
    end
    for (int i = 0; i < 2; i++) begin
      if (hit[i]) begin
        e_taken[complete_tag[i]]  <= complete_taken[i];
        e_target[complete_tag[i]] <= complete_target[i];
        e_misp[complete_tag[i]]   <= complete_mispredict[i];
      end
    end
  end

  // Registered retire, predictor-update, squash and halt outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rob_retire       <= '0;
      ARCH_ARF_idx     <= '0;
      ARCH_PRF_idx     <= '0;
      retired          <= '0;
      dest_PRN_out     <= '0;
      valid_update     <= '0;
      PC_update        <= '0;
      direction_update <= '0;
      target_update    <= '0;
      squash           <= 1'b0;
      squash_pc        <= '0;
      halt_retired     <= 1'b0;
    end else begin
      rob_retire       <= rob_retire_d;
      ARCH_ARF_idx     <= arf_d;
      ARCH_PRF_idx     <= prf_d;
      retired          <= rob_retire_d;
      dest_PRN_out     <= prf_d;
      valid_update     <= valid_update_d;
      PC_update        <= pc_d;
      direction_update <= direction_update_d;
      target_update    <= target_d;
      squash           <= flush;
      squash_pc        <= flush ? flush_pc : 32'd0;
      halt_retired     <= halt_retired | halt_hit;
    end
  end

endmodule

// File: tb/tb_rob_retire_unit.sv
// tb_rob_retire_unit: directed scenarios for rob_retire_unit with a commit
// scoreboard. Every register-writing instruction expected to commit is
// pushed as {arn, prn} when dispatched and popped when the DUT commits it.
module tb_rob_retire_unit;
  localparam int ROB_DEPTH = 32;
  localparam int PRF_W     = 6;
  localparam int ROB_W     = 5;

  logic                  clock, reset;
  logic [1:0]            dispatch_valid, dispatch_reg_write, dispatch_is_branch, dispatch_halt;
  logic [1:0][4:0]       dispatch_arn;
  logic [1:0][PRF_W-1:0] dispatch_prn;
  logic [1:0][31:0]      dispatch_pc;
  logic [1:0][ROB_W-1:0] dispatch_tag;
  logic                  rob_stall;
  logic [1:0]            complete_valid, complete_taken, complete_mispredict;
  logic [1:0][ROB_W-1:0] complete_tag;
  logic [1:0][31:0]      complete_target;
  logic [1:0]            rob_retire, retired, valid_update, direction_update;
  logic [1:0][4:0]       ARCH_ARF_idx;
  logic [1:0][PRF_W-1:0] ARCH_PRF_idx, dest_PRN_out;
  logic [1:0][31:0]      PC_update, target_update;
  logic                  squash, halt_retired;
  logic [31:0]           squash_pc;
  logic [ROB_W:0]        dbg_count;
  logic [ROB_W-1:0]      dbg_head, dbg_tail;

  int checks   = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  rob_retire_unit #(.ROB_DEPTH(ROB_DEPTH), .PRF_W(PRF_W)) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_arn(dispatch_arn),
    .dispatch_prn(dispatch_prn), .dispatch_reg_write(dispatch_reg_write),
    .dispatch_pc(dispatch_pc), .dispatch_is_branch(dispatch_is_branch),
    .dispatch_halt(dispatch_halt), .dispatch_tag(dispatch_tag),
    .rob_stall(rob_stall), .complete_valid(complete_valid),
    .complete_tag(complete_tag), .complete_taken(complete_taken),
    .complete_target(complete_target), .complete_mispredict(complete_mispredict),
    .rob_retire(rob_retire), .ARCH_ARF_idx(ARCH_ARF_idx),
    .ARCH_PRF_idx(ARCH_PRF_idx), .retired(retired),
    .dest_PRN_out(dest_PRN_out), .valid_update(valid_update),
    .PC_update(PC_update), .direction_update(direction_update),
    .target_update(target_update), .squash(squash), .squash_pc(squash_pc),
    .halt_retired(halt_retired), .dbg_count(dbg_count),
    .dbg_head(dbg_head), .dbg_tail(dbg_tail)
  );

  // Clock and reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every commit strobe must match the oldest expected entry.
  task automatic monitor();
    logic [10:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rob_retire[i] || retired[i]) begin
        check_eq("commit_strobes", {rob_retire[i], retired[i]}, 2'b11);
        if (exp_q.size() == 0) begin
          check_eq("commit_unexpected", {rob_retire[i], retired[i]}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check_eq("commit_arn", ARCH_ARF_idx[i], e[10:6]);
          check_eq("commit_prn", ARCH_PRF_idx[i], e[5:0]);
          check_eq("prf_commit_prn", dest_PRN_out[i], e[5:0]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    monitor();
  endtask

  // Driver tasks.
  task automatic clear_inputs();
    dispatch_valid      = '0;
    dispatch_arn        = '0;
    dispatch_prn        = '0;
    dispatch_reg_write  = '0;
    dispatch_pc         = '0;
    dispatch_is_branch  = '0;
    dispatch_halt       = '0;
    complete_valid      = '0;
    complete_tag        = '0;
    complete_taken      = '0;
    complete_target     = '0;
    complete_mispredict = '0;
  endtask

  task automatic disp_slot(input int s, input logic [4:0] arn, input logic [PRF_W-1:0] prn,
                           input logic rw, input logic [31:0] pc, input logic br,
                           input logic hlt, input logic commit);
    dispatch_valid[s]     = 1'b1;
    dispatch_arn[s]       = arn;
    dispatch_prn[s]       = prn;
    dispatch_reg_write[s] = rw;
    dispatch_pc[s]        = pc;
    dispatch_is_branch[s] = br;
    dispatch_halt[s]      = hlt;
    if (commit && rw) exp_q.push_back({arn, prn});
  endtask

  task automatic comp_slot(input int s, input logic [ROB_W-1:0] tag, input logic taken,
                           input logic [31:0] target, input logic misp);
    complete_valid[s]      = 1'b1;
    complete_tag[s]        = tag;
    complete_taken[s]      = taken;
    complete_target[s]     = target;
    complete_mispredict[s] = misp;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    // Reset state.
    check_eq("rst_stall", rob_stall, 1'b0);
    check_eq("rst_tag", dispatch_tag, {5'd1, 5'd0});
    check_eq("rst_retire", rob_retire, 2'b00);
    check_eq("rst_squash", squash, 1'b0);
    check_eq("rst_halt", halt_retired, 1'b0);
    check_eq("rst_count", dbg_count, 6'd0);
    reset = 1'b1;
    tick();

    // 1: dispatch two, complete both, retire both two edges after dispatch.
    check_eq("t1_tag", dispatch_tag, {5'd1, 5'd0});
    disp_slot(0, 5'd5, 6'd33, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    disp_slot(1, 5'd6, 6'd34, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    comp_slot(0, 5'd0, 1'b0, 32'h4, 1'b0);
    comp_slot(1, 5'd1, 1'b0, 32'h8, 1'b0);
    tick();
    clear_inputs();
    check_eq("t1_not_yet", rob_retire, 2'b00);
    tick();
    check_eq("t1_retire", rob_retire, 2'b11);
    check_eq("t1_arf", ARCH_ARF_idx, {5'd6, 5'd5});
    check_eq("t1_prf", ARCH_PRF_idx, {6'd34, 6'd33});
    tick();
    check_eq("t1_pulse", rob_retire, 2'b00);

    // 2: younger completes first; both retire together once the older is done.
    check_eq("t2_tag", dispatch_tag, {5'd3, 5'd2});
    disp_slot(0, 5'd7, 6'd40, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    disp_slot(1, 5'd8, 6'd41, 1'b1, 32'hc, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    comp_slot(0, 5'd3, 1'b0, 32'h10, 1'b0);
    tick();
    clear_inputs();
    tick();
    check_eq("t2_wait_a", rob_retire, 2'b00);
    tick();
    check_eq("t2_wait_b", rob_retire, 2'b00);
    comp_slot(1, 5'd2, 1'b0, 32'hc, 1'b0);
    tick();
    clear_inputs();
    check_eq("t2_wait_c", rob_retire, 2'b00);
    tick();
    check_eq("t2_retire", rob_retire, 2'b11);

    // 3: mispredicted branch at head; younger done entry is squashed.
    check_eq("t3_tag", dispatch_tag, {5'd5, 5'd4});
    disp_slot(0, 5'd0, 6'd0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0);
    disp_slot(1, 5'd9, 6'd42, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    comp_slot(0, 5'd4, 1'b1, 32'h200, 1'b1);
    comp_slot(1, 5'd5, 1'b0, 32'h108, 1'b0);
    tick();
    clear_inputs();
    tick();
    check_eq("t3_vupd", valid_update, 2'b01);
    check_eq("t3_pc", PC_update[0], 32'h100);
    check_eq("t3_target", target_update[0], 32'h200);
    check_eq("t3_dir", direction_update[0], 1'b1);
    check_eq("t3_retire", rob_retire, 2'b00);
    check_eq("t3_squash", squash, 1'b1);
    check_eq("t3_squash_pc", squash_pc, 32'h200);
    check_eq("t3_count", dbg_count, 6'd0);
    check_eq("t3_tag_reset", dispatch_tag, {5'd1, 5'd0});
    disp_slot(0, 5'd10, 6'd43, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check_eq("t3_squash_pulse", squash, 1'b0);
    check_eq("t3_disp_dropped", dbg_count, 6'd0);
    check_eq("t3_vupd_pulse", valid_update, 2'b00);

    // 4: fill to full, overflow is dropped, retire frees space, tail wraps.
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        check_eq("t4_stall_30", rob_stall, 1'b0);
        check_eq("t4_count_30", dbg_count, 6'd30);
      end
      disp_slot(0, 5'(2*k), 6'(2*k), 1'b1, 32'(8*k), 1'b0, 1'b0, 1'b1);
      disp_slot(1, 5'(2*k+1), 6'(2*k+1), 1'b1, 32'(8*k+4), 1'b0, 1'b0, 1'b1);
      tick();
      clear_inputs();
    end
    check_eq("t4_stall_full", rob_stall, 1'b1);
    check_eq("t4_count_full", dbg_count, 6'd32);
    check_eq("t4_tail_wrap", dispatch_tag, {5'd1, 5'd0});
    disp_slot(0, 5'd1, 6'd63, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check_eq("t4_drop_count", dbg_count, 6'd32);
    check_eq("t4_drop_tail", dispatch_tag, {5'd1, 5'd0});
    comp_slot(0, 5'd0, 1'b0, 32'h4, 1'b0);
    comp_slot(1, 5'd1, 1'b0, 32'h8, 1'b0);
    tick();
    clear_inputs();
    // Dispatch on the retiring edge still sees a full buffer.
    disp_slot(0, 5'd2, 6'd62, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check_eq("t4_retire", rob_retire, 2'b11);
    check_eq("t4_count_after", dbg_count, 6'd30);
    check_eq("t4_stall_clear", rob_stall, 1'b0);
    check_eq("t4_same_edge_drop", dispatch_tag, {5'd1, 5'd0});
    for (int k = 1; k < 16; k++) begin
      comp_slot(0, 5'(2*k), 1'b0, 32'h0, 1'b0);
      comp_slot(1, 5'(2*k+1), 1'b0, 32'h0, 1'b0);
      tick();
      clear_inputs();
    end
    for (int k = 0; k < 3; k++) tick();
    check_eq("t4_drain_count", dbg_count, 6'd0);
    check_eq("t4_drain_sb", exp_q.size(), 0);

    // 5: halt at head blocks the done entry behind it and further dispatch.
    disp_slot(0, 5'd0, 6'd0, 1'b0, 32'h300, 1'b0, 1'b1, 1'b0);
    disp_slot(1, 5'd3, 6'd50, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    comp_slot(0, 5'd0, 1'b0, 32'h304, 1'b0);
    comp_slot(1, 5'd1, 1'b0, 32'h308, 1'b0);
    tick();
    clear_inputs();
    tick();
    check_eq("t5_halt", halt_retired, 1'b1);
    check_eq("t5_no_commit", rob_retire, 2'b00);
    check_eq("t5_count", dbg_count, 6'd1);
    tick();
    tick();
    check_eq("t5_still_blocked", rob_retire, 2'b00);
    check_eq("t5_sticky", halt_retired, 1'b1);
    disp_slot(0, 5'd4, 6'd51, 1'b1, 32'h308, 1'b0, 1'b0, 1'b0);
    tick();
    clear_inputs();
    check_eq("t5_disp_ignored", dbg_count, 6'd1);
    check_eq("t5_tail_held", dispatch_tag, {5'd3, 5'd2});

    // 6: asynchronous reset with ten live entries.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("t6_halt_cleared", halt_retired, 1'b0);
    for (int k = 0; k < 6; k++) begin
      disp_slot(0, 5'(11+2*k), 6'(20+2*k), 1'b1, 32'(8*k), 1'b0, 1'b0, (k == 0));
      disp_slot(1, 5'(12+2*k), 6'(21+2*k), 1'b1, 32'(8*k+4), 1'b0, 1'b0, (k == 0));
      tick();
      clear_inputs();
    end
    comp_slot(0, 5'd0, 1'b0, 32'h4, 1'b0);
    comp_slot(1, 5'd1, 1'b0, 32'h8, 1'b0);
    tick();
    clear_inputs();
    tick();
    check_eq("t6_retire_before", rob_retire, 2'b11);
    check_eq("t6_count_live", dbg_count, 6'd10);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_retire_async", rob_retire, 2'b00);
    check_eq("t6_retired_async", retired, 2'b00);
    check_eq("t6_arf_async", ARCH_ARF_idx, 10'd0);
    check_eq("t6_count_async", dbg_count, 6'd0);
    check_eq("t6_tag_async", dispatch_tag, {5'd1, 5'd0});
    check_eq("t6_stall_async", rob_stall, 1'b0);
    #1;
    reset = 1'b1;
    tick();
    check_eq("t6_idle_retire", rob_retire, 2'b00);
    check_eq("t6_idle_count", dbg_count, 6'd0);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
